// File: rtl/tff_dff_sync.sv
// Single rising-edge flip-flop with synchronous active-high clear.
// Holds zero from time zero so the toggle chain never starts from X.
module dff_sync (
  output logic q,
  input  logic d,
  input  logic clk,
  input  logic reset
);

  logic r_q = 1'b0;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_q <= 1'b0;
    end else begin
      r_q <= d;
    end
  end

  assign q = r_q;

endmodule

// File: rtl/tff.sv
// WIDTH independent toggle flip-flops: each bit inverts on a rising edge when its T bit is set.
// Reset is synchronous and dominates T.
module tff #(
  parameter int WIDTH = 1
) (
  output logic [WIDTH-1:0] out,
  input  logic [WIDTH-1:0] T,
  input  logic             clk,
  input  logic             reset
);

  logic [WIDTH-1:0] w_next;

  assign w_next = out ^ T;

  // state boundary: one flop per bit, next state = out XOR T
  for (genvar g = 0; g < WIDTH; g++) begin : g_bit
    dff_sync u_dff (
      .q     (out[g]),
      .d     (w_next[g]),
      .clk   (clk),
      .reset (reset)
    );
  end

endmodule

// File: tb/tb_tff.sv
// Bench for tff: a 1-bit and a 4-bit instance on one 20 ns clock, checked 2 ns after
// every clock transition against a per-bit toggle model, plus literal checkpoints.
module tb_tff;

  logic       clk = 1'b0;
  logic [0:0] t1  = '0;
  logic       r1  = 1'b0;
  logic [3:0] t4  = '0;
  logic       r4  = 1'b0;
  logic [0:0] out1;
  logic [3:0] out4;

  int vectors     = 0;
  int miscompares = 0;

  bit exp1;
  bit exp4 [4];

  tff #(.WIDTH(1)) dut1 (.out(out1), .T(t1), .clk(clk), .reset(r1));
  tff #(.WIDTH(4)) dut4 (.out(out4), .T(t4), .clk(clk), .reset(r4));

  always #10 clk = ~clk;

  task automatic chk(input string name, input logic [3:0] act, input logic [3:0] req);
    vectors++;
    if (act !== req) begin
      miscompares++;
      $display("FAIL %s at %0t: got %b, expected %b", name, $time, act, req);
    end
  endtask

  function automatic logic [3:0] pack4();
    logic [3:0] v;
    for (int i = 0; i < 4; i++) v[i] = exp4[i];
    return v;
  endfunction

  // Reference model advances on rising edges only; every transition is checked 2 ns later.
  initial begin
    exp1 = 1'b0;
    for (int i = 0; i < 4; i++) exp4[i] = 1'b0;
    forever begin
      @(clk);
      if (clk === 1'b1) begin
        if (r1) exp1 = 1'b0;
        else if (t1[0]) exp1 = !exp1;
        for (int i = 0; i < 4; i++) begin
          if (r4) exp4[i] = 1'b0;
          else if (t4[i]) exp4[i] = !exp4[i];
        end
      end
      #2;
      chk("model_w1", {3'b000, out1}, {3'b000, exp1});
      chk("model_w4", out4, pack4());
    end
  end

  // Advance to 5 ns after the next rising edge, where inputs are driven.
  task automatic step();
    @(posedge clk);
    #5;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time %0t exceeded, expected finish earlier", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    // Power-up value before any edge or reset
    t1 = 1'b1;
    #1;
    chk("powerup_w1", {3'b000, out1}, 4'b0000);
    chk("powerup_w4", out4, 4'b0000);

    // Free-running toggle: edges at 10,30,50,70 ns
    step(); chk("toggle_e1", {3'b000, out1}, 4'b0001);
    step(); chk("toggle_e2", {3'b000, out1}, 4'b0000);
    step(); chk("toggle_e3", {3'b000, out1}, 4'b0001);
    step(); chk("toggle_e4", {3'b000, out1}, 4'b0000);

    // Hold with T=0 after reaching 1
    step();
    t1 = 1'b0;
    for (int k = 0; k < 4; k++) step();
    chk("hold_4edges", {3'b000, out1}, 4'b0001);

    // Reset dominates T, then toggling resumes from 0
    t1 = 1'b1;
    r1 = 1'b1;
    step(); chk("reset_dom", {3'b000, out1}, 4'b0000);
    step();
    step(); chk("reset_held", {3'b000, out1}, 4'b0000);
    r1 = 1'b0;
    step(); chk("reset_release", {3'b000, out1}, 4'b0001);

    // Reset pulse entirely between edges has no effect
    t1 = 1'b0;
    r1 = 1'b1;
    #2;
    r1 = 1'b0;
    step(); chk("reset_glitch", {3'b000, out1}, 4'b0001);

    // Independent bits on the 4-bit instance
    r4 = 1'b1;
    step();
    r4 = 1'b0;
    t4 = 4'b0101;
    step(); chk("w4_0101", out4, 4'b0101);
    t4 = 4'b0011;
    step(); chk("w4_0110", out4, 4'b0110);

    // Random T and occasional reset, with T glitching between edges
    for (int k = 0; k < 300; k++) begin
      t1 = 1'($urandom);
      t4 = 4'($urandom);
      r1 = ($urandom_range(0, 7) == 0);
      r4 = ($urandom_range(0, 7) == 0);
      #3;
      t1 = ~t1;
      t4 = ~t4;
      #2;
      t1 = ~t1;
      t4 = ~t4;
      step();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/tff.md
TFF -- requirements
Module: tff

Interface
- REQ-001: The block SHALL have one parameter: WIDTH, default 1, number of independent toggle bits.
- REQ-002: Port `clk` SHALL be: input, 1 bit, sole clock; all state updates on rising edge.
- REQ-003: Port `reset` SHALL be: input, 1 bit, synchronous, active-high clear.
- REQ-004: Port `out` SHALL be: output, WIDTH bits, registered flip-flop state.
- REQ-005: Port `T` SHALL be: input, WIDTH bits, per-bit toggle enable.
- REQ-006: Positional port order SHALL be (out, T, clk, reset).
  - A three-port positional instance (out, T, clk) leaves `reset` unconnected and still works.
- REQ-007: The block SHALL have one clock and a synchronous, active-high reset.

Function
- REQ-008: At each rising `clk` edge with reset=0, each bit out[i] SHALL take ~out[i] when T[i]=1 and hold when T[i]=0.
- REQ-009: `out` SHALL change only at rising `clk` edges, with one-edge latency.
  - `T` sampled at edge k affects `out` immediately after edge k, never before.
- REQ-010: Falling clock edges and changes of `T` between edges SHALL NOT affect `out`.
- REQ-011: Bits SHALL be independent; toggling bit i SHALL NOT disturb any other bit.
- REQ-012: `out` SHALL power up as all-zeros at simulation time zero, with no X, before any edge or reset.
- REQ-013: The combinational path SHALL be next = out XOR T.
  - No combinational path from `T` to `out`.

Reset
- REQ-014: A rising `clk` edge with reset=1 SHALL load out = 0 for all bits.
- REQ-015: Reset SHALL dominate T (reset=1 with T=1 yields 0, not a toggle).
- REQ-016: Reset asserted between edges SHALL have no effect until the next rising edge.
- REQ-017: An unconnected or low `reset` SHALL behave as 0.
- REQ-018: After reset deasserts, toggling SHALL resume from 0 at the first edge with reset=0.

Structure
- REQ-019: The state element SHALL be a sub-module `dff_sync` instantiated WIDTH times via generate.
  - `dff_sync` ports: q, d, clk, reset.
  - Behaviour: rising-edge, synchronous clear, initial value 0.
- REQ-020: Toggle logic SHALL be an XOR of `out` and `T` feeding `d`; no other logic.
- REQ-021: No shared package SHALL be required.
  - WIDTH is the only constant and is local.

Verification
- REQ-022: Scenario: WIDTH=1, T=1, reset unconnected, clk period 20 ns starting low, 80 ns run -> out=0 before the first edge; out=1,0,1,0 after edges at 10,30,50,70 ns.
- REQ-023: Scenario: T=0 for 4 edges after out=1 -> out stays 1; falling edges cause no change.
- REQ-024: Scenario: out=1, T=1, reset=1 at an edge -> out=0; reset=1 for 3 edges with T=1 -> out stays 0; reset back to 0 -> next edge out=1.
- REQ-025: Scenario: reset pulsed high and low entirely between two edges -> out unchanged.
- REQ-026: Scenario: WIDTH=4, out=0000, T=0101 for 1 edge -> 0101; then T=0011 -> 0110.
- REQ-027: Self-check: every scenario compares `out` 2 ns after each clk transition against a reference model Exp, where Exp inverts on each posedge with T=1 and clears on reset; all comparisons equal.
